// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared states, timing defaults and sizing helpers for the camera transmitter
// Contents:
//   cam_state_e      frame sequencer states (IDLE -> VSYNC -> VBACK -> ACTIVE -> VFRONT)
//   CAM_* constants  default VGA-style timing
//   cam_width()      counter width able to hold 0..max_val-1 (never zero bits)
//   cam_max()        larger of two integers, for sizing the shared row counter
package cam_pkg;

  localparam int CAM_H_ACTIVE    = 640;
  localparam int CAM_V_ACTIVE    = 480;
  localparam int CAM_H_BLANK     = 144;
  localparam int CAM_VSYNC_LINES = 3;
  localparam int CAM_V_BACK      = 17;
  localparam int CAM_V_FRONT     = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } cam_state_e;

  // $clog2(1) and $clog2(2) would give 0/1 bits; a counter always needs at least one.
  function automatic int cam_width(input int max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

  function automatic int cam_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_transmitter_if.sv
// rtl/cam_transmitter_if.sv - pixel input stream and camera output bus of the transmitter
// Signals:
//   enable_i       permits new frames to start
//   pixel_valid_i  pixel_i holds a valid RGB565 pixel
//   pixel_i        16-bit RGB565 pixel
//   pixel_ready_o  pixel buffer can accept a pixel
//   d_o            camera data byte D0-D7
//   vsync_o        VSYNC, active-high
//   href_o         HREF, high during active bytes
//   frame_done_o   one-cycle pulse on the last cycle of the front porch
//   underflow_o    sticky: a pixel was needed but the buffer was empty
// Modports: slave = transmitter side, master = pixel source / camera sink side.
interface cam_transmitter_if;

  logic        enable_i;
  logic        pixel_valid_i;
  logic [15:0] pixel_i;
  logic        pixel_ready_o;
  logic [7:0]  d_o;
  logic        vsync_o;
  logic        href_o;
  logic        frame_done_o;
  logic        underflow_o;

  modport slave (
    input  enable_i, pixel_valid_i, pixel_i,
    output pixel_ready_o, d_o, vsync_o, href_o, frame_done_o, underflow_o
  );

  modport master (
    output enable_i, pixel_valid_i, pixel_i,
    input  pixel_ready_o, d_o, vsync_o, href_o, frame_done_o, underflow_o
  );

endinterface

// File: rtl/cam_timing_gen.sv
// rtl/cam_timing_gen.sv - frame sequencer with row/column counters and sync/slot strobes
// Ports:
//   pclk_i        pixel clock
//   rst_i         asynchronous active-high reset
//   enable_i      permits a new frame to start (sampled in IDLE and on the last VFRONT cycle)
//   vsync_o       high for the whole VSYNC state
//   href_o        high for the first 2*H_ACTIVE cycles of every ACTIVE line
//   hi_slot_o     href cycle that carries a pixel's high byte (even column)
//   frame_done_o  last cycle of the front porch
// All outputs are decoded from registered state, so they only move on pclk_i rising edges.
module cam_timing_gen
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = CAM_H_ACTIVE,
  parameter int V_ACTIVE    = CAM_V_ACTIVE,
  parameter int H_BLANK     = CAM_H_BLANK,
  parameter int VSYNC_LINES = CAM_VSYNC_LINES,
  parameter int V_BACK      = CAM_V_BACK,
  parameter int V_FRONT     = CAM_V_FRONT
) (
  input  logic pclk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic vsync_o,
  output logic href_o,
  output logic hi_slot_o,
  output logic frame_done_o
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int COL_W    = cam_width(LINE_LEN);
  localparam int ROW_MAX  = cam_max(cam_max(VSYNC_LINES, V_BACK), cam_max(V_ACTIVE, V_FRONT));
  localparam int ROW_W    = cam_width(ROW_MAX);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_LEN - 1);
  // Compared with <= so the bound still fits COL_W when H_BLANK is zero.
  localparam logic [COL_W-1:0] HREF_LAST = COL_W'(2 * H_ACTIVE - 1);

  localparam logic [ROW_W-1:0] ROW_VSYNC_LAST  = ROW_W'(VSYNC_LINES - 1);
  localparam logic [ROW_W-1:0] ROW_VBACK_LAST  = ROW_W'(V_BACK - 1);
  localparam logic [ROW_W-1:0] ROW_ACTIVE_LAST = ROW_W'(V_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_VFRONT_LAST = ROW_W'(V_FRONT - 1);

  cam_state_e       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] row_last;
  logic             line_last;
  logic             state_last;
  logic             href;

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    row_last   = '0;
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;

    case (state_q)
      VSYNC:   row_last = ROW_VSYNC_LAST;
      VBACK:   row_last = ROW_VBACK_LAST;
      ACTIVE:  row_last = ROW_ACTIVE_LAST;
      VFRONT:  row_last = ROW_VFRONT_LAST;
      default: row_last = '0;
    endcase

    line_last  = (col_q == COL_LAST);
    state_last = line_last && (row_q == row_last);

    if (state_q == IDLE) begin
      col_d = '0;
      row_d = '0;
      if (enable_i) begin
        state_d = VSYNC;
      end
    end else begin
      // Every state is a whole number of LINE_LEN lines; the row counter
      // restarts at each state boundary so it never exceeds the longest state.
      if (line_last) begin
        col_d = '0;
        row_d = state_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (state_last) begin
        case (state_q)
          VSYNC:   state_d = VBACK;
          VBACK:   state_d = ACTIVE;
          ACTIVE:  state_d = VFRONT;
          // enable_i only matters here, so a frame in flight always completes.
          VFRONT:  state_d = enable_i ? VSYNC : IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign href         = (state_q == ACTIVE) && (col_q <= HREF_LAST);
  assign href_o       = href;
  assign hi_slot_o    = href && !col_q[0];
  assign vsync_o      = (state_q == VSYNC);
  assign frame_done_o = (state_q == VFRONT) && state_last;

endmodule

// File: rtl/cam_transmitter.sv
// rtl/cam_transmitter.sv - RGB565 pixel stream to 8-bit DVP-style camera bus transmitter
// Ports:
//   pclk_i  pixel clock; every output changes only on its rising edge
//   rst_i   asynchronous active-high reset; aborts any frame in progress
//   bus     cam_transmitter_if.slave: enable_i, pixel_valid_i/pixel_i/pixel_ready_o in,
//           d_o, vsync_o, href_o, frame_done_o, underflow_o out
// The timing generator owns the frame sequence; this level holds the one-pixel
// buffer, the low-byte holding register and the sticky underflow flag.
module cam_transmitter
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = CAM_H_ACTIVE,
  parameter int V_ACTIVE    = CAM_V_ACTIVE,
  parameter int H_BLANK     = CAM_H_BLANK,
  parameter int VSYNC_LINES = CAM_VSYNC_LINES,
  parameter int V_BACK      = CAM_V_BACK,
  parameter int V_FRONT     = CAM_V_FRONT
) (
  input logic             pclk_i,
  input logic             rst_i,
  cam_transmitter_if.slave bus
);

  logic        vsync;
  logic        href;
  logic        hi_slot;
  logic        frame_done;

  logic [15:0] buf_data;
  logic        buf_valid;
  logic [7:0]  lo_byte;
  logic        underflow;
  logic        load;
  logic [7:0]  d_byte;

  cam_timing_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .V_ACTIVE    (V_ACTIVE),
    .H_BLANK     (H_BLANK),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BACK      (V_BACK),
    .V_FRONT     (V_FRONT)
  ) u_timing (
    .pclk_i       (pclk_i),
    .rst_i        (rst_i),
    .enable_i     (bus.enable_i),
    .vsync_o      (vsync),
    .href_o       (href),
    .hi_slot_o    (hi_slot),
    .frame_done_o (frame_done)
  );

  // The buffer accepts in any state, including IDLE and blanking, so the
  // first pixel of each line is already waiting when href rises.
  assign load = bus.pixel_valid_i && !buf_valid;

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_data  <= '0;
      buf_valid <= 1'b0;
      lo_byte   <= '0;
      underflow <= 1'b0;
    end else begin
      // The high byte goes out straight from the buffer; the low byte is
      // parked so the buffer is free to refill during the low-byte cycle.
      if (hi_slot) begin
        lo_byte <= buf_valid ? buf_data[7:0] : 8'h00;
        if (!buf_valid) begin
          underflow <= 1'b1;
        end
      end

      // load implies buf_valid was 0, so it never collides with a drain.
      if (load) begin
        buf_data  <= bus.pixel_i;
        buf_valid <= 1'b1;
      end else if (hi_slot) begin
        buf_valid <= 1'b0;
      end
    end
  end

  // An empty buffer at a high-byte slot sends a 0x00,0x00 pixel; timing is untouched.
  always_comb begin
    d_byte = 8'h00;
    if (hi_slot) begin
      d_byte = buf_valid ? buf_data[15:8] : 8'h00;
    end else if (href) begin
      d_byte = lo_byte;
    end
  end

  assign bus.pixel_ready_o = !buf_valid;
  assign bus.d_o           = d_byte;
  assign bus.vsync_o       = vsync;
  assign bus.href_o        = href;
  assign bus.frame_done_o  = frame_done;
  assign bus.underflow_o   = underflow;

endmodule

// File: tb/tb_cam_transmitter.sv
// tb/tb_cam_transmitter.sv - self-checking bench for cam_transmitter
module tb_cam_transmitter;

  localparam int H_ACTIVE    = 4;
  localparam int V_ACTIVE    = 2;
  localparam int H_BLANK     = 3;
  localparam int VSYNC_LINES = 1;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 1;

  typedef struct {
    int         cyc;
    bit         en;
    bit         pv;
    bit         vs;
    bit         hr;
    logic [7:0] d;
    bit         fd;
    bit         uf;
  } vec_t;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  cam_transmitter_if bus();

  cam_transmitter #(
    .H_ACTIVE    (H_ACTIVE),
    .V_ACTIVE    (V_ACTIVE),
    .H_BLANK     (H_BLANK),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BACK      (V_BACK),
    .V_FRONT     (V_FRONT)
  ) dut (
    .pclk_i (pclk),
    .rst_i  (rst),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  vec_t        tbl[$];
  logic [15:0] seq [0:15];
  logic [7:0]  t1_l0 [0:7];
  logic [7:0]  t1_l1 [0:7];
  int          checks  = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          src_idx = 0;
  bit          src_pv  = 1'b0;

  // Loopback receiver: active-low reset driven by the inverted rst.
  logic        rx_rstn;
  logic        rx_prev_vs;
  logic        rx_phase;
  logic [7:0]  rx_hi;
  int          rx_frame;
  int          rx_cnt [0:3];
  logic [15:0] rx_pix [0:3][0:7];

  assign rx_rstn = !rst;

  always @(negedge pclk) begin
    if (!rx_rstn) begin
      rx_prev_vs <= 1'b0;
      rx_phase   <= 1'b0;
      rx_hi      <= 8'h00;
      rx_frame   <= 0;
      for (int f = 0; f < 4; f++) rx_cnt[f] <= 0;
    end else begin
      rx_prev_vs <= bus.vsync_o;
      if (bus.vsync_o && !rx_prev_vs && rx_frame < 3) rx_frame <= rx_frame + 1;
      if (bus.href_o) begin
        if (!rx_phase) begin
          rx_hi    <= bus.d_o;
          rx_phase <= 1'b1;
        end else begin
          rx_phase <= 1'b0;
          if (rx_cnt[rx_frame] < 8) rx_pix[rx_frame][rx_cnt[rx_frame]] <= {rx_hi, bus.d_o};
          rx_cnt[rx_frame] <= rx_cnt[rx_frame] + 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [11:0] obs();
    return {bus.vsync_o, bus.href_o, bus.d_o, bus.frame_done_o, bus.underflow_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    bus.pixel_valid_i = src_pv;
    bus.pixel_i       = seq[src_idx % 16];
  endtask

  task automatic step();
    bit hs;
    hs = bus.pixel_valid_i && bus.pixel_ready_o && !rst;
    @(posedge pclk);
    #1;
    if (hs) src_idx++;
    cyc++;
    drive_src();
  endtask

  task automatic start_test();
    rst            = 1'b1;
    bus.enable_i   = 1'b0;
    src_pv         = 1'b0;
    src_idx        = 0;
    drive_src();
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic add(input int c, input bit en, input bit pv, input bit vs, input bit hr,
                     input logic [7:0] d, input bit fd, input bit uf);
    vec_t v;
    v.cyc = c; v.en = en; v.pv = pv; v.vs = vs; v.hr = hr; v.d = d; v.fd = fd; v.uf = uf;
    tbl.push_back(v);
  endtask

  task automatic run_vectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      while (cyc < tbl[i].cyc) step();
      check($sformatf("vec%0d_c%0d", i, tbl[i].cyc), {20'h0, obs()},
            {20'h0, tbl[i].vs, tbl[i].hr, tbl[i].d, tbl[i].fd, tbl[i].uf});
      bus.enable_i = tbl[i].en;
      src_pv       = tbl[i].pv;
      drive_src();
    end
  endtask

  initial begin
    int t1_first, t1_last, t2_first, t2_last;
    int fd_cyc, hits, first_vs, first_hr;
    logic [7:0] first_d;

    seq = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978,
            16'h8796, 16'hA5B4, 16'hC3D2, 16'hE1F0, 16'h1357, 16'h2468, 16'hACE0, 16'hBDF1};
    t1_l0 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    t1_l1 = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78};

    bus.enable_i = 1'b0;
    drive_src();

    // Continuous frames: c0 is the IDLE cycle in which enable_i first rises.
    t1_first = tbl.size();
    add(0,  1, 1, 0, 0, 8'h00, 0, 0);
    add(1,  1, 1, 1, 0, 8'h00, 0, 0);
    add(11, 1, 1, 1, 0, 8'h00, 0, 0);
    add(12, 1, 1, 0, 0, 8'h00, 0, 0);
    add(22, 1, 1, 0, 0, 8'h00, 0, 0);
    for (int k = 0; k < 8; k++) add(23 + k, 1, 1, 0, 1, t1_l0[k], 0, 0);
    add(31, 1, 1, 0, 0, 8'h00, 0, 0);
    add(33, 1, 1, 0, 0, 8'h00, 0, 0);
    for (int k = 0; k < 8; k++) add(34 + k, 1, 1, 0, 1, t1_l1[k], 0, 0);
    add(42,  1, 1, 0, 0, 8'h00, 0, 0);
    add(54,  1, 1, 0, 0, 8'h00, 0, 0);
    add(55,  1, 1, 0, 0, 8'h00, 1, 0);
    add(56,  1, 1, 1, 0, 8'h00, 0, 0);
    add(66,  1, 1, 1, 0, 8'h00, 0, 0);
    add(67,  1, 1, 0, 0, 8'h00, 0, 0);
    add(78,  1, 1, 0, 1, 8'h87, 0, 0);
    add(79,  1, 1, 0, 1, 8'h96, 0, 0);
    add(110, 1, 1, 0, 0, 8'h00, 1, 0);
    add(111, 1, 1, 1, 0, 8'h00, 0, 0);
    t1_last = tbl.size() - 1;

    // Third pixel of line 0 withheld for its one load cycle (c26).
    t2_first = tbl.size();
    add(0,  1, 1, 0, 0, 8'h00, 0, 0);
    add(1,  1, 1, 1, 0, 8'h00, 0, 0);
    add(11, 1, 1, 1, 0, 8'h00, 0, 0);
    add(12, 1, 1, 0, 0, 8'h00, 0, 0);
    add(22, 1, 1, 0, 0, 8'h00, 0, 0);
    add(23, 1, 1, 0, 1, 8'h12, 0, 0);
    add(24, 1, 1, 0, 1, 8'h34, 0, 0);
    add(25, 1, 1, 0, 1, 8'h56, 0, 0);
    add(26, 1, 0, 0, 1, 8'h78, 0, 0);
    add(27, 1, 1, 0, 1, 8'h00, 0, 0);
    add(28, 1, 1, 0, 1, 8'h00, 0, 1);
    add(29, 1, 1, 0, 1, 8'h9A, 0, 1);
    add(30, 1, 1, 0, 1, 8'hBC, 0, 1);
    add(31, 1, 1, 0, 0, 8'h00, 0, 1);
    add(33, 1, 1, 0, 0, 8'h00, 0, 1);
    add(34, 1, 1, 0, 1, 8'hDE, 0, 1);
    add(35, 1, 1, 0, 1, 8'hF0, 0, 1);
    add(36, 1, 1, 0, 1, 8'h0F, 0, 1);
    add(37, 1, 1, 0, 1, 8'h1E, 0, 1);
    add(41, 1, 1, 0, 1, 8'h5A, 0, 1);
    add(42, 1, 1, 0, 0, 8'h00, 0, 1);
    add(55, 1, 1, 0, 0, 8'h00, 1, 1);
    add(56, 1, 1, 1, 0, 8'h00, 0, 1);
    t2_last = tbl.size() - 1;

    // Reset state.
    step();
    step();
    check("reset_outputs", {19'h0, obs(), bus.pixel_ready_o}, {19'h0, 12'h000, 1'b1});

    start_test();
    run_vectors(t1_first, t1_last);

    start_test();
    run_vectors(t2_first, t2_last);

    // enable_i dropped mid-ACTIVE: frame finishes, then IDLE.
    start_test();
    bus.enable_i = 1'b1;
    src_pv       = 1'b1;
    drive_src();
    while (cyc < 30) step();
    check("drop_en_in_active", {31'h0, bus.href_o}, 32'h1);
    bus.enable_i = 1'b0;
    fd_cyc = -1;
    for (int k = 0; k < 200 && fd_cyc < 0; k++) begin
      step();
      if (bus.frame_done_o) fd_cyc = cyc;
    end
    check("drop_en_frame_done_cycle", fd_cyc, 55);
    step();
    check("drop_en_idle_outputs", {20'h0, obs()}, 32'h0);
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.vsync_o || bus.href_o) hits++;
    end
    check("drop_en_stays_idle", hits, 0);

    // Reset mid-line: outputs clear immediately, clean frame after release.
    start_test();
    bus.enable_i = 1'b1;
    src_pv       = 1'b1;
    drive_src();
    while (cyc < 25) step();
    check("midline_before_reset", {20'h0, obs()}, {20'h0, 1'b0, 1'b1, 8'h56, 1'b0, 1'b0});
    rst = 1'b1;
    #1;
    check("midline_reset_outputs", {19'h0, obs(), bus.pixel_ready_o}, {19'h0, 12'h000, 1'b1});
    src_pv  = 1'b0;
    src_idx = 0;
    drive_src();
    step();
    step();
    rst    = 1'b0;
    src_pv = 1'b1;
    drive_src();
    cyc      = 0;
    first_vs = -1;
    first_hr = -1;
    first_d  = 8'h00;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.vsync_o && first_vs < 0) first_vs = cyc;
      if (bus.href_o && first_hr < 0) begin
        first_hr = cyc;
        first_d  = bus.d_o;
      end
    end
    check("restart_first_vsync", first_vs, 1);
    check("restart_first_href", first_hr, 23);
    check("restart_first_byte", {24'h0, first_d}, 32'h12);
    check("restart_no_underflow", {31'h0, bus.underflow_o}, 32'h0);

    // Loopback into the receiver model across two frames.
    start_test();
    bus.enable_i = 1'b1;
    src_pv       = 1'b1;
    drive_src();
    while (cyc < 112) step();
    bus.enable_i = 1'b0;
    step();
    check("loop_frame1_count", rx_cnt[1], 8);
    check("loop_frame2_count", rx_cnt[2], 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("loop_frame2_pix%0d", k), {16'h0, rx_pix[2][k]}, {16'h0, seq[8 + k]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
